// File: rtl/cmp_lteq_pkg.sv
// cmp_lteq_pkg: shared state encoding and default sizes for the comparator arbiter
package cmp_lteq_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, EVAL = 2'd1, RESP = 2'd2} cmp_arb_state_e;
  localparam int CMP_WIDTH = 32;
  localparam int CMP_NUM_REQ = 4;
endpackage

// File: rtl/cmp_lteq_core.sv
// cmp_lteq_core: combinational unsigned a <= b comparator
module cmp_lteq_core #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             lteq
);
  assign lteq = a <= b;
endmodule

// File: rtl/cmp_lteq_arbiter.sv
// cmp_lteq_arbiter: round-robin sharing of one unsigned <= comparator among NUM_REQ requesters
// Define CMP_LTEQ_ARB_PIPE_EN to register the comparator result (EVAL state, latency 2).
module cmp_lteq_arbiter
  import cmp_lteq_pkg::*;
#(
  parameter int NUM_REQ = CMP_NUM_REQ,
  parameter int WIDTH   = CMP_WIDTH,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic                     rsp_lteq,
  output logic [ID_W-1:0]          rsp_id
);
  cmp_arb_state_e state_q;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d, op_id_q, gnt_idx;
  logic [WIDTH-1:0] op_a_q, op_b_q;
  logic gnt_found, can_arb, take, core_lteq;
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[(int'(rr_ptr_q) + k) % NUM_REQ]) begin
        gnt_found = 1'b1;
        gnt_idx   = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      end
    end
  end
  // Grants are also suppressed while reset is held so req_ready reads 0 immediately.
  assign can_arb  = rst_n && (state_q == IDLE || (state_q == RESP && rsp_ready));
  assign take     = can_arb && gnt_found;
  assign rr_ptr_d = (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) req_ready[i] = take && gnt_idx == ID_W'(i);
  end
  cmp_lteq_core #(.WIDTH(WIDTH)) u_core (.a(op_a_q), .b(op_b_q), .lteq(core_lteq));
  assign rsp_valid = state_q == RESP;
  assign rsp_id    = op_id_q;
`ifdef CMP_LTEQ_ARB_PIPE_EN
  logic lteq_q;
  assign rsp_lteq = rsp_valid && lteq_q;
`else
  assign rsp_lteq = rsp_valid && core_lteq;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      op_id_q  <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
`ifdef CMP_LTEQ_ARB_PIPE_EN
      lteq_q   <= 1'b0;
`endif
    end else begin
      if (take) begin
        op_a_q   <= req_a[gnt_idx*WIDTH +: WIDTH];
        op_b_q   <= req_b[gnt_idx*WIDTH +: WIDTH];
        op_id_q  <= gnt_idx;
        rr_ptr_q <= rr_ptr_d;
      end
`ifdef CMP_LTEQ_ARB_PIPE_EN
      if (state_q == EVAL) lteq_q <= core_lteq;
      state_q <= take ? EVAL : (state_q == EVAL) ? RESP :
                 (state_q == RESP && rsp_ready) ? IDLE : state_q;
`else
      state_q <= take ? RESP : (state_q == RESP && rsp_ready) ? IDLE : state_q;
`endif
    end
  end
endmodule
